// File: rtl/irq_pkg.sv
// irq_pkg: constants and types shared by the machine interrupt block.
// Cause codes, mip bit positions, timer register map and request state.
package irq_pkg;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    localparam logic [1:0] TMR_CMP_LO  = 2'd0;
    localparam logic [1:0] TMR_CMP_HI  = 2'd1;
    localparam logic [1:0] TMR_TIME_LO = 2'd2;
    localparam logic [1:0] TMR_TIME_HI = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } irq_state_e;

    // mcause value for an interrupt with the given code
    function automatic logic [31:0] mk_cause(input logic [3:0] code);
        return {1'b1, 27'b0, code};
    endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync: multi-flop synchroniser for one asynchronous level input,
// followed by a rising-edge detector on the synchronised signal.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the raw level through the chain and remember the last output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-mode interrupt sources, masking and request register.
// Define IRQ_CLINT_TIMER_EN to build the mtime/mtimecmp timer and MTIP.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_EXT_IRQ = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 1,
    localparam int IDW = (NUM_EXT_IRQ > 1) ? $clog2(NUM_EXT_IRQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_EXT_IRQ-1:0] ext_irq_i,
    input  logic                   sw_irq_set,
    input  logic                   sw_irq_clr,
    input  logic                   tmr_we,
    input  logic [1:0]             tmr_addr,
    input  logic [31:0]            tmr_wdata,
    output logic [31:0]            tmr_rdata,
    input  logic [31:0]            mie,
    input  logic                   mstatus_mie,
    output logic [31:0]            mip,
    output logic                   interrupt,
    output logic [31:0]            irq_cause,
    output logic [IDW-1:0]         irq_src_id,
    input  logic                   irq_ack
);

    logic [NUM_EXT_IRQ-1:0] rise;
    logic [NUM_EXT_IRQ-1:0] clr_mask;
    logic [NUM_EXT_IRQ-1:0] ext_pend_q;
    logic [NUM_EXT_IRQ-1:0] ext_pend_d;
    logic                   msip_q;
    logic                   msip_d;
    logic                   mtip;

    irq_state_e             state_q;
    irq_state_e             state_d;
    logic [31:0]            cause_q;
    logic [31:0]            cause_d;
    logic [IDW-1:0]         src_q;
    logic [IDW-1:0]         src_d;
    logic [1:0]             blank_q;
    logic [1:0]             blank_d;

    logic [31:0]            en;
    logic                   eligible;
    logic                   ack_take;
    logic [3:0]             win_code;
    logic [IDW-1:0]         low_id;

    for (genvar g = 0; g < NUM_EXT_IRQ; g++) begin : g_sync
        irq_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk     (clk),
            .rst     (rst),
            .async_i (ext_irq_i[g]),
            .rise_o  (rise[g])
        );
    end

`ifdef IRQ_CLINT_TIMER_EN
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [31:0]   cmp_lo_q;
    logic [31:0]   cmp_lo_d;
    logic [31:0]   cmp_hi_q;
    logic [31:0]   cmp_hi_d;
    logic [31:0]   time_lo_q;
    logic [31:0]   time_lo_d;
    logic [31:0]   time_hi_q;
    logic [31:0]   time_hi_d;
    logic          mtip_q;
    logic          mtip_d;
    logic          tick;
    logic          carry;

    // Prescaler, 64-bit counter with per-half writes, compare register
    always_comb begin
        tick      = (presc_q == PW'(TICK_DIV - 1));
        presc_d   = tick ? '0 : presc_q + PW'(1);
        carry     = tick && (time_lo_q == 32'hFFFF_FFFF);
        cmp_lo_d  = cmp_lo_q;
        cmp_hi_d  = cmp_hi_q;
        time_lo_d = time_lo_q + {31'b0, tick};
        time_hi_d = time_hi_q + {31'b0, carry};
        if (tmr_we) begin
            unique case (tmr_addr)
                TMR_CMP_LO: cmp_lo_d = tmr_wdata;
                TMR_CMP_HI: cmp_hi_d = tmr_wdata;
                TMR_TIME_LO: begin
                    time_lo_d = tmr_wdata;
                    time_hi_d = time_hi_q;
                end
                TMR_TIME_HI: time_hi_d = tmr_wdata;
            endcase
        end
        mtip_d = {time_hi_q, time_lo_q} >= {cmp_hi_q, cmp_lo_q};
    end

    // Timer state; mtimecmp starts at all ones so MTIP stays low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= '0;
            cmp_lo_q  <= 32'hFFFF_FFFF;
            cmp_hi_q  <= 32'hFFFF_FFFF;
            time_lo_q <= '0;
            time_hi_q <= '0;
            mtip_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            cmp_lo_q  <= cmp_lo_d;
            cmp_hi_q  <= cmp_hi_d;
            time_lo_q <= time_lo_d;
            time_hi_q <= time_hi_d;
            mtip_q    <= mtip_d;
        end
    end

    // Combinational register read at tmr_addr
    always_comb begin
        tmr_rdata = cmp_lo_q;
        unique case (tmr_addr)
            TMR_CMP_LO:  tmr_rdata = cmp_lo_q;
            TMR_CMP_HI:  tmr_rdata = cmp_hi_q;
            TMR_TIME_LO: tmr_rdata = time_lo_q;
            TMR_TIME_HI: tmr_rdata = time_hi_q;
        endcase
    end

    assign mtip = mtip_q;
`else
    localparam int unused_tick_div = TICK_DIV;

    logic unused_tmr;

    assign unused_tmr = ^{tmr_we, tmr_addr, tmr_wdata};
    assign tmr_rdata  = '0;
    assign mtip       = 1'b0;
`endif

    // Pending vector as seen by CSR reads
    always_comb begin
        mip           = '0;
        mip[MIP_MSIP] = msip_q;
        mip[MIP_MTIP] = mtip;
        mip[MIP_MEIP] = |ext_pend_q;
    end

    assign en       = mip & mie;
    assign ack_take = irq_ack && (state_q == ST_REQ);
    assign eligible = mstatus_mie && (|en) && (blank_q == 2'd0);

    // Lowest-numbered pending external line
    always_comb begin
        low_id = '0;
        for (int i = NUM_EXT_IRQ - 1; i >= 0; i--) begin
            if (ext_pend_q[i]) low_id = IDW'(i);
        end
    end

    // Fixed priority MEI > MSI > MTI among enabled sources
    always_comb begin
        win_code = CAUSE_MTI;
        if (en[MIP_MEIP]) begin
            win_code = CAUSE_MEI;
        end else if (en[MIP_MSIP]) begin
            win_code = CAUSE_MSI;
        end
    end

    // Claim clears the taken line; a same-cycle new edge wins
    always_comb begin
        clr_mask = '0;
        if (ack_take && (cause_q[3:0] == CAUSE_MEI)) begin
            clr_mask[src_q] = 1'b1;
        end
        ext_pend_d = (ext_pend_q & ~clr_mask) | rise;
        msip_d     = sw_irq_set | (msip_q & ~sw_irq_clr);
    end

    // Request FSM: freeze the winner, retire on ack or on masking
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        src_d   = src_q;
        blank_d = blank_q;
        if (blank_q != 2'd0) blank_d = blank_q - 2'd1;
        unique case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    state_d = ST_REQ;
                    cause_d = mk_cause(win_code);
                    src_d   = low_id;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_d = ST_IDLE;
                    blank_d = 2'd2;
                end else if (!mstatus_mie || !en[cause_q[3:0]]) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Source and request state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_pend_q <= '0;
            msip_q     <= 1'b0;
            state_q    <= ST_IDLE;
            cause_q    <= '0;
            src_q      <= '0;
            blank_q    <= '0;
        end else begin
            ext_pend_q <= ext_pend_d;
            msip_q     <= msip_d;
            state_q    <= state_d;
            cause_q    <= cause_d;
            src_q      <= src_d;
            blank_q    <= blank_d;
        end
    end

    assign interrupt  = (state_q == ST_REQ);
    assign irq_cause  = cause_q;
    assign irq_src_id = src_q;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Machine-mode interrupt source block, directly upstream of the exception unit.
- Synchronises external interrupt lines and latches them as pending on a rising edge; also holds the software interrupt bit.
- Contains a 64-bit machine timer (mtime/mtimecmp) that raises the timer interrupt.
- Masks the pending set with mie and mstatus.MIE, picks one winner by priority, and presents it to the exception unit. Exports mip for CSR reads.

Parameters:
- NUM_EXT_IRQ, 4: number of external interrupt lines.
- SYNC_STAGES, 2: flip-flop depth of each input synchroniser (minimum 2).
- TICK_DIV, 1: mtime increments once every TICK_DIV clocks (minimum 1).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-low.
- ext_irq_i  in  NUM_EXT_IRQ  asynchronous level inputs.
- sw_irq_set  in  1  sets MSIP.
- sw_irq_clr  in  1  clears MSIP.
- tmr_we  in  1  timer register write strobe (MEM stage).
- tmr_addr  in  2  timer register select: 0 mtimecmp_lo, 1 mtimecmp_hi, 2 mtime_lo, 3 mtime_hi.
- tmr_wdata  in  32  timer write data.
- tmr_rdata  out  32  combinational read of the register at tmr_addr.
- mie  in  32  mie CSR value.
- mstatus_mie  in  1  mstatus[3].
- mip  out  32  pending vector: bit 3 MSIP, bit 7 MTIP, bit 11 MEIP, all other bits 0.
- interrupt  out  1  interrupt request to the exception unit.
- irq_cause  out  32  mcause value for the request: {1'b1, 27'b0, code}.
- irq_src_id  out  $clog2(NUM_EXT_IRQ)  lowest pending external line.
- irq_ack  in  1  exception unit took the trap (one-cycle pulse).

Behaviour:
- Reset (rst low, asynchronous):
  - synchronisers, ext_pend, MSIP, mtime, prescaler and ack_blank clear to 0;
  - mtimecmp resets to all ones;
  - interrupt=0, irq_cause=0, irq_src_id=0, mip=0.
  - Reset asserted mid-request drops the request immediately; no ack is expected afterwards.
- External lines:
  - Each line passes through SYNC_STAGES flip-flops and then an edge detector.
  - A rising edge sets ext_pend[i].
  - MEIP = |ext_pend.
- External claim: irq_ack while irq_cause code is 11 clears ext_pend[irq_src_id]. If a new edge on the same line arrives in the same cycle, set wins and the bit stays pending.
- MSIP: sw_irq_set and sw_irq_clr in the same cycle leaves MSIP=1.
- Timer:
  - The prescaler counts 0..TICK_DIV-1; mtime increments by 1 when it wraps.
  - mtime wraps from 2^64-1 to 0.
  - A tmr_we to an mtime half overrides that half's increment in the same cycle; the other half keeps counting, with carry from the unwritten lo half.
  - MTIP = (mtime >= mtimecmp), unsigned 64-bit compare, level-sensitive, registered into mip.
- Selection:
  - en = mip & mie.
  - Fixed priority MEI(11) > MSI(3) > MTI(7).
  - A request is eligible when mstatus_mie=1, |en, and ack_blank=0.
- Request register, two states:
  - IDLE: interrupt=0. Enter REQ on the next edge when a request is eligible, registering irq_cause and irq_src_id.
  - REQ: interrupt=1, and irq_cause and irq_src_id stay frozen.
  - REQ -> IDLE on irq_ack. This also sets ack_blank for 2 cycles so the exception unit can clear MIE.
  - REQ -> IDLE, with no ack, when mstatus_mie falls or the frozen cause's en bit clears. The request is then re-evaluated from IDLE.
- Latency:
  - ext_irq_i edge -> interrupt high in SYNC_STAGES+2 cycles.
  - mtime crossing mtimecmp -> interrupt high in 2 cycles.
- irq_ack while interrupt=0 is ignored.

Optional Feature:
- Macro: IRQ_CLINT_TIMER_EN.
- Defined: timer, prescaler and MTIP logic exist as described above.
- Undefined:
  - no timer registers;
  - mip[7]=0;
  - tmr_rdata=0;
  - tmr_we is ignored;
  - TICK_DIV is unused.

Decomposition:
- Package irq_pkg holds:
  - cause codes CAUSE_MSI=3, CAUSE_MTI=7, CAUSE_MEI=11;
  - mip bit positions;
  - TMR_CMP_LO / TMR_CMP_HI / TMR_TIME_LO / TMR_TIME_HI address encodings;
  - the IDLE/REQ state typedef.
- One sub-module, irq_sync: SYNC_STAGES synchroniser plus rising-edge detector, instantiated once per line.

Test Plan:
- Edge to ack: mie=0x800, mstatus_mie=1, pulse ext_irq_i[2] -> interrupt=1 after 4 cycles with irq_cause=0x8000000B and irq_src_id=2. Then irq_ack -> interrupt=0 next cycle and ext_pend[2]=0.
- Priority: set MSIP and raise ext line 0 together, mie=0x888 -> irq_cause=0x8000000B first. After the ack and 2 blank cycles -> irq_cause=0x80000003.
- Timer: write mtimecmp={0,100}, mtime=90, TICK_DIV=1, mie=0x80 -> interrupt rises when mtime reaches 100 (+2 cycles). Writing mtimecmp_lo=0xFFFFFFFF -> interrupt drops.
- Mask drop: in REQ, drop mstatus_mie -> interrupt=0 next cycle with no ack. Restore mstatus_mie -> the request reappears.
- Mid-request reset: assert rst low while interrupt=1 -> all outputs 0 at once and mtimecmp reads 0xFFFFFFFF.
- Carry and set-wins: mtime_lo=0xFFFFFFFF increments -> hi +1. Ack coinciding with a new edge on the same line -> ext_pend stays 1.
